// File: rtl/hazard_stall_ctrl.sv
// Hazard, stall/flush and forwarding control for the 5-stage pipeline.
// Also tracks the multi-cycle mult/div unit so HI/LO readers wait.
module hazard_stall_ctrl #(
   parameter int MD_LATENCY = 4,
   parameter int CNT_W      = 3
) (
   input  logic       CLOCK,
   input  logic       RESET,
   input  logic [4:0] RsD,
   input  logic [4:0] RtD,
   input  logic [4:0] RsE,
   input  logic [4:0] RtE,
   input  logic [4:0] WriteRegE,
   input  logic [4:0] WriteRegM,
   input  logic [4:0] WriteRegW,
   input  logic       RegWriteE,
   input  logic       RegWriteM,
   input  logic       RegWriteW,
   input  logic       MemtoRegE,
   input  logic       MemtoRegM,
   input  logic       BranchD,
   input  logic       PCSrcD,
   input  logic       HiLoUseD,
   input  logic       MulDivE,
   output logic       StallF,
   output logic       StallD,
   output logic       FlushD,
   output logic       FlushE,
   output logic       ForwardAD,
   output logic       ForwardBD,
   output logic [1:0] ForwardAE,
   output logic [1:0] ForwardBE,
   output logic       MdBusy
);

   typedef enum logic {
      IDLE,
      MD_BUSY
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MD_LATENCY - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             md_busy_q, md_busy_d;

   logic       lwstall, branchstall, mdstall, stall;
   logic       fad, fbd;
   logic [1:0] fae, fbe;

   // $0 is hard-wired, so a zero destination never matches
   function automatic logic hit(
      input logic       we,
      input logic [4:0] dst,
      input logic [4:0] src
   );
      return we && (dst != 5'd0) && (dst == src);
   endfunction

   always_comb begin
      fae = 2'b00;
      fbe = 2'b00;
      if (hit(RegWriteM, WriteRegM, RsE)) begin
         fae = 2'b10;
      end else if (hit(RegWriteW, WriteRegW, RsE)) begin
         fae = 2'b01;
      end
      if (hit(RegWriteM, WriteRegM, RtE)) begin
         fbe = 2'b10;
      end else if (hit(RegWriteW, WriteRegW, RtE)) begin
         fbe = 2'b01;
      end
   end

   always_comb begin
      fad = hit(RegWriteM, WriteRegM, RsD);
      fbd = hit(RegWriteM, WriteRegM, RtD);
      lwstall = MemtoRegE &&
                (hit(RegWriteE, WriteRegE, RsD) ||
                 hit(RegWriteE, WriteRegE, RtD));
      branchstall = BranchD &&
                    (hit(RegWriteE, WriteRegE, RsD) ||
                     hit(RegWriteE, WriteRegE, RtD) ||
                     hit(MemtoRegM, WriteRegM, RsD) ||
                     hit(MemtoRegM, WriteRegM, RtD));
      mdstall = HiLoUseD && md_busy_q;
      stall = lwstall || branchstall || mdstall;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (MulDivE) begin
               state_d = MD_BUSY;
               cnt_d   = CNT_LOAD;
            end
         end
         MD_BUSY: begin
            if (cnt_q == '0) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
      md_busy_d = (state_d == MD_BUSY);
   end

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         md_busy_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         md_busy_q <= md_busy_d;
      end
   end

   // A stall wins over a taken branch: PCSrcD is not yet valid then
   always_comb begin
      StallF    = ~RESET & stall;
      StallD    = ~RESET & stall;
      FlushE    = ~RESET & stall;
      FlushD    = ~RESET & PCSrcD & ~stall;
      ForwardAD = ~RESET & fad;
      ForwardBD = ~RESET & fbd;
      ForwardAE = RESET ? 2'b00 : fae;
      ForwardBE = RESET ? 2'b00 : fbe;
      MdBusy    = md_busy_q;
   end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl with an expected-value queue.
// Outputs are packed as {SF,SD,FD,FE,FAD,FBD,FAE,FBE,BUSY}.
module tb_hazard_stall_ctrl;

   logic       CLOCK = 1'b0;
   logic       RESET;
   logic [4:0] RsD, RtD, RsE, RtE;
   logic [4:0] WriteRegE, WriteRegM, WriteRegW;
   logic       RegWriteE, RegWriteM, RegWriteW;
   logic       MemtoRegE, MemtoRegM;
   logic       BranchD, PCSrcD, HiLoUseD, MulDivE;
   logic       StallF, StallD, FlushD, FlushE;
   logic       ForwardAD, ForwardBD, MdBusy;
   logic [1:0] ForwardAE, ForwardBE;

   int tests = 0;
   int fails = 0;

   logic [10:0] exp_q[$];
   string       tag_q[$];

   always #5 CLOCK = ~CLOCK;

   hazard_stall_ctrl #(
      .MD_LATENCY(4),
      .CNT_W(3)
   ) dut (
      .CLOCK(CLOCK), .RESET(RESET),
      .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
      .WriteRegE(WriteRegE), .WriteRegM(WriteRegM),
      .WriteRegW(WriteRegW),
      .RegWriteE(RegWriteE), .RegWriteM(RegWriteM),
      .RegWriteW(RegWriteW),
      .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM),
      .BranchD(BranchD), .PCSrcD(PCSrcD),
      .HiLoUseD(HiLoUseD), .MulDivE(MulDivE),
      .StallF(StallF), .StallD(StallD),
      .FlushD(FlushD), .FlushE(FlushE),
      .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
      .MdBusy(MdBusy)
   );

   function automatic logic [10:0] ex(
      input logic       st,
      input logic       fd,
      input logic       fad,
      input logic       fbd,
      input logic [1:0] fae,
      input logic [1:0] fbe,
      input logic       busy
   );
      return {st, st, fd, st, fad, fbd, fae, fbe, busy};
   endfunction

   task automatic clear_in();
      RsD = 0; RtD = 0; RsE = 0; RtE = 0;
      WriteRegE = 0; WriteRegM = 0; WriteRegW = 0;
      RegWriteE = 0; RegWriteM = 0; RegWriteW = 0;
      MemtoRegE = 0; MemtoRegM = 0;
      BranchD = 0; PCSrcD = 0; HiLoUseD = 0; MulDivE = 0;
   endtask

   // Push expectation, compare at the falling edge, advance one cycle
   task automatic step(input string tag, input logic [10:0] e);
      logic [10:0] obs, want;
      string       t;
      exp_q.push_back(e);
      tag_q.push_back(tag);
      @(negedge CLOCK);
      obs = {StallF, StallD, FlushD, FlushE, ForwardAD, ForwardBD,
             ForwardAE, ForwardBE, MdBusy};
      want = exp_q.pop_front();
      t = tag_q.pop_front();
      tests++;
      assert (obs === want) else begin
         fails++;
         $error("FAIL %s: observed %b expected %b", t, obs, want);
      end
      @(posedge CLOCK);
      #1;
   endtask

   initial begin
      clear_in();
      RESET = 1;
      RsD = 8; MemtoRegE = 1; RegWriteE = 1; WriteRegE = 8;
      PCSrcD = 1; RegWriteM = 1; WriteRegM = 5; RsE = 5;
      step("reset_outputs", ex(0, 0, 0, 0, 2'b00, 2'b00, 0));

      RESET = 0;
      clear_in();
      MemtoRegE = 1; RegWriteE = 1; WriteRegE = 8; RsD = 8; RtD = 9;
      step("load_use_stall", ex(1, 0, 0, 0, 2'b00, 2'b00, 0));

      clear_in();
      RegWriteM = 1; MemtoRegM = 1; WriteRegM = 8;
      RsE = 8; RtE = 9; RegWriteE = 1; WriteRegE = 10;
      RsD = 1; RtD = 2;
      step("load_use_fwd_m", ex(0, 0, 0, 0, 2'b10, 2'b00, 0));

      clear_in();
      RegWriteM = 1; RegWriteW = 1;
      WriteRegM = 5; WriteRegW = 5; RsE = 5;
      step("fwd_m_priority", ex(0, 0, 0, 0, 2'b10, 2'b00, 0));

      WriteRegM = 6;
      step("fwd_w", ex(0, 0, 0, 0, 2'b01, 2'b00, 0));

      RsE = 0; WriteRegW = 0; RtE = 6;
      step("fwd_zero_a_m_b", ex(0, 0, 0, 0, 2'b00, 2'b10, 0));

      RtE = 7; WriteRegW = 7;
      step("fwd_b_w", ex(0, 0, 0, 0, 2'b00, 2'b01, 0));

      clear_in();
      BranchD = 1; RsD = 3; RegWriteE = 1; WriteRegE = 3; PCSrcD = 1;
      step("branch_stall_e", ex(1, 0, 0, 0, 2'b00, 2'b00, 0));

      clear_in();
      BranchD = 1; RsD = 3; PCSrcD = 1;
      RegWriteM = 1; WriteRegM = 3;
      step("branch_fwd_flush", ex(0, 1, 1, 0, 2'b00, 2'b00, 0));

      clear_in();
      BranchD = 1; RtD = 4;
      RegWriteM = 1; MemtoRegM = 1; WriteRegM = 4;
      step("branch_stall_load_m", ex(1, 0, 0, 1, 2'b00, 2'b00, 0));

      clear_in();
      MemtoRegE = 1; RegWriteE = 1; WriteRegE = 12; RtD = 12;
      PCSrcD = 1;
      step("lwstall_over_pcsrc", ex(1, 0, 0, 0, 2'b00, 2'b00, 0));

      clear_in();
      MemtoRegE = 1; RegWriteE = 1; BranchD = 1;
      RegWriteM = 1; MemtoRegM = 1; RegWriteW = 1;
      step("reg0_no_hazard", ex(0, 0, 0, 0, 2'b00, 2'b00, 0));

      clear_in();
      PCSrcD = 1;
      step("taken_flush", ex(0, 1, 0, 0, 2'b00, 2'b00, 0));

      clear_in();
      HiLoUseD = 1; MulDivE = 1;
      step("md_issue", ex(0, 0, 0, 0, 2'b00, 2'b00, 0));
      MulDivE = 0;
      step("md_busy1", ex(1, 0, 0, 0, 2'b00, 2'b00, 1));
      RegWriteW = 1; WriteRegW = 5; RsE = 5;
      step("md_busy2_fwd_w", ex(1, 0, 0, 0, 2'b01, 2'b00, 1));
      RegWriteW = 0; WriteRegW = 0; RsE = 0;
      step("md_busy3", ex(1, 0, 0, 0, 2'b00, 2'b00, 1));
      step("md_busy4", ex(1, 0, 0, 0, 2'b00, 2'b00, 1));
      step("md_done", ex(0, 0, 0, 0, 2'b00, 2'b00, 0));

      clear_in();
      HiLoUseD = 1; MulDivE = 1;
      step("md2_issue", ex(0, 0, 0, 0, 2'b00, 2'b00, 0));
      MulDivE = 0;
      step("md2_busy1", ex(1, 0, 0, 0, 2'b00, 2'b00, 1));
      step("md2_busy2", ex(1, 0, 0, 0, 2'b00, 2'b00, 1));
      RESET = 1;
      MemtoRegE = 1; RegWriteE = 1; WriteRegE = 8; RsD = 8;
      RegWriteM = 1; WriteRegM = 5; RsE = 5; RtE = 5; PCSrcD = 1;
      step("rst_gate_busy", ex(0, 0, 0, 0, 2'b00, 2'b00, 1));
      step("rst_abort", ex(0, 0, 0, 0, 2'b00, 2'b00, 0));
      RESET = 0;
      clear_in();
      HiLoUseD = 1;
      step("post_rst_idle", ex(0, 0, 0, 0, 2'b00, 2'b00, 0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
